fifo_rd_serializer: RTL

- Downstream consumer of the 1-write/1-read synchronous FIFO.
- Pops one wide word from the FIFO head and emits it as RATIO narrow beats on a valid/ready stream, flagging the last beat.
- Sustains one beat per cycle with no bubble between consecutive FIFO words.
- Never pops an empty FIFO.

---
 rtl/fifo_ser_pkg.sv | 14 +
 rtl/fifo_rd_serializer.sv | 98 +++++++++
 2 files changed

// File: rtl/fifo_ser_pkg.sv
// Shared types and helpers for the FIFO read-side serializer.
package fifo_ser_pkg;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_t;

    // Number of narrow beats per wide word; zero when the output is wider than the input.
    function automatic int ser_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

endpackage

// File: rtl/fifo_rd_serializer.sv
// Pops wide words from a show-ahead FIFO and streams them out as RATIO narrow
// valid/ready beats, loading the next word on the last beat without a bubble.
module fifo_rd_serializer
    import fifo_ser_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 fifo_valid,
    input  logic [IN_WIDTH-1:0]  fifo_rd_data,
    output logic                 fifo_pop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int RATIO = ser_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

    if (RATIO < 1 || RATIO * OUT_WIDTH != IN_WIDTH) begin : g_bad_ratio
        $error("fifo_rd_serializer: IN_WIDTH must be a multiple of OUT_WIDTH");
    end

    ser_state_t          state_reg;
    logic [CNT_W-1:0]    beat_cnt_reg;
    logic [IN_WIDTH-1:0] shift_reg;
    logic                out_valid_reg;
    logic [IN_WIDTH-1:0] shift_next;

    logic accept;
    logic last_acc;
    logic load;

    assign accept   = out_valid_reg & out_ready;
    assign last_acc = accept & (beat_cnt_reg == LAST_BEAT);
    assign load     = fifo_valid & ((state_reg == SER_IDLE) | last_acc);
    assign fifo_pop = load;

    // The current beat always sits at the emitting end of the shift register.
    if (RATIO == 1) begin : g_single
        assign shift_next = '0;
        assign out_data   = shift_reg;
    end else if (LSB_FIRST != 0) begin : g_lsb
        assign shift_next = {{OUT_WIDTH{1'b0}}, shift_reg[IN_WIDTH-1:OUT_WIDTH]};
        assign out_data   = shift_reg[OUT_WIDTH-1:0];
    end else begin : g_msb
        assign shift_next = {shift_reg[IN_WIDTH-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
        assign out_data   = shift_reg[IN_WIDTH-1 -: OUT_WIDTH];
    end

    assign out_valid = out_valid_reg;
    assign out_last  = out_valid_reg & (beat_cnt_reg == LAST_BEAT);
    assign busy      = (state_reg != SER_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= SER_IDLE;
            beat_cnt_reg  <= '0;
            shift_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                SER_IDLE: begin
                    if (load) begin
                        shift_reg     <= fifo_rd_data;
                        beat_cnt_reg  <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= SER_SEND;
                    end
                end
                SER_SEND: begin
                    if (load) begin
                        // Last beat taken and the next word is waiting: reload in place.
                        shift_reg     <= fifo_rd_data;
                        beat_cnt_reg  <= '0;
                    end else if (last_acc) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= SER_IDLE;
                    end else if (accept) begin
                        shift_reg     <= shift_next;
                        beat_cnt_reg  <= beat_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg     <= SER_IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
